pc_jump_unit: RTL and testbench

- Hack program-counter stage that consumes the jump-condition terms built from the Or gate: (j1 & ng) | (j2 & zr) | (j3 & !zr & !ng).
- Holds the instruction address presented to the ROM fetch stage.
- On each retired instruction, either loads the A-register target or increments.
- Also detects the unconditional jump-to-self end-of-program idiom and flags halt, and keeps a saturating retired-instruction count for test benches.

---
 rtl/pc_jump_unit.sv | 70 +++++++
 tb/tb_pc_jump_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_jump_unit.sv
// Hack program-counter stage: loads the A-register target on a taken jump or
// increments, detects the unconditional jump-to-self halt idiom and counts retirements.
module pc_jump_unit #(
  parameter int WIDTH       = 15,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   advance,
  input  logic                   isCInstr,
  input  logic [2:0]             jump,
  input  logic                   zr,
  input  logic                   ng,
  input  logic [WIDTH-1:0]       target,
  output logic [WIDTH-1:0]       pc,
  output logic                   jumpTaken,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retireCount
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic                   take;
  logic                   accept;
  logic [WIDTH-1:0]       pc_nxt;
  logic                   jump_taken_nxt;
  logic [COUNT_WIDTH-1:0] retire_count_nxt;

  // zr & ng together is illegal from the ALU but is evaluated literally.
  assign take   = isCInstr & ((jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~zr & ~ng));
  assign accept = advance & (state == RUN);
  assign halted = (state == HALT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt        = state;
    pc_nxt           = pc;
    jump_taken_nxt   = jumpTaken;
    retire_count_nxt = retireCount;
    if (accept) begin
      pc_nxt         = take ? target : pc + WIDTH'(1);
      jump_taken_nxt = take;
      if (retireCount != {COUNT_WIDTH{1'b1}})
        retire_count_nxt = retireCount + COUNT_WIDTH'(1);
      // Only the unconditional form of jump-to-self ends the program.
      if (take && (jump == 3'b111) && (target == pc))
        state_nxt = HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= '0;
      jumpTaken   <= 1'b0;
      retireCount <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      jumpTaken   <= jump_taken_nxt;
      retireCount <= retire_count_nxt;
    end
  end

endmodule

// File: tb/tb_pc_jump_unit.sv
// Self-checking bench for pc_jump_unit: directed scenarios plus random traffic,
// checked through a scoreboard queue against a behavioural model.
module tb_pc_jump_unit;

  localparam int W  = 15;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          advance = 1'b0;
  logic          isCInstr = 1'b0;
  logic [2:0]    jump = 3'b000;
  logic          zr = 1'b0;
  logic          ng = 1'b0;
  logic [W-1:0]  target = '0;
  logic [W-1:0]  pc;
  logic          jumpTaken;
  logic          halted;
  logic [CW-1:0] retireCount;

  // Small-counter instance for saturation.
  logic          rst2_n = 1'b0;
  logic          adv2 = 1'b0;
  logic [W-1:0]  pc2;
  logic          jt2;
  logic          halted2;
  logic [3:0]    cnt2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int            due;
    logic [W-1:0]  pc;
    logic          jt;
    logic          halt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state.
  int m_pc = 0;
  bit m_jt = 0;
  bit m_halt = 0;
  int m_cnt = 0;

  pc_jump_unit #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .isCInstr(isCInstr),
    .jump(jump), .zr(zr), .ng(ng), .target(target),
    .pc(pc), .jumpTaken(jumpTaken), .halted(halted), .retireCount(retireCount)
  );

  pc_jump_unit #(.WIDTH(W), .COUNT_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .advance(adv2), .isCInstr(1'b0),
    .jump(3'b000), .zr(1'b0), .ng(1'b0), .target(15'h0000),
    .pc(pc2), .jumpTaken(jt2), .halted(halted2), .retireCount(cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares each expected entry once the edge it describes has passed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", 32'(pc), 32'(e.pc));
      check("jumpTaken", 32'(jumpTaken), 32'(e.jt));
      check("halted", 32'(halted), 32'(e.halt));
      check("retireCount", 32'(retireCount), 32'(e.cnt));
    end
  end

  // Called at posedge+1; applies one cycle of stimulus and returns at the next posedge+1.
  task automatic drive(input bit adv, input bit isc, input bit [2:0] j, input bit z,
                       input bit n, input int tgt);
    exp_t e;
    bit   tk;
    advance  = adv;
    isCInstr = isc;
    jump     = j;
    zr       = z;
    ng       = n;
    target   = W'(tgt);
    if (adv && !m_halt) begin
      // A C-instruction jumps if the ALU result class (neg / zero / pos) is selected.
      tk = isc && ((j[2] && n) || (j[1] && z) || (j[0] && !z && !n));
      if (tk && j == 3'b111 && tgt == m_pc) m_halt = 1;
      m_pc  = tk ? tgt : (m_pc + 1) % (1 << W);
      m_jt  = tk;
      m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    end
    e.due  = cyc + 1;
    e.pc   = W'(m_pc);
    e.jt   = m_jt;
    e.halt = m_halt;
    e.cnt  = CW'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset; returns at posedge+1 with reset released.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    advance = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_jumpTaken", 32'(jumpTaken), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retireCount", 32'(retireCount), 32'd0);
    check("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_pc = 0; m_jt = 0; m_halt = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1. Power-on reset for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("por_pc", 32'(pc), 32'd0);
    check("por_halted", 32'(halted), 32'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // 2. A-instruction retirements, then idle cycles.
    repeat (3) drive(1, 0, 3'b111, 0, 1, 16'h1234);
    repeat (4) drive(0, 1, 3'b111, $urandom_range(1), $urandom_range(1), $urandom);

    // Reach pc=5 and reset asynchronously mid-cycle.
    repeat (2) drive(1, 0, 3'b000, 0, 0, 0);
    check("pre_reset_pc5", 32'(pc), 32'd5);
    do_reset();

    // 3. JGT taken with positive result, then not taken with negative result.
    drive(1, 1, 3'b001, 0, 0, 16'h0100);
    drive(1, 1, 3'b001, 0, 1, 16'h0100);

    // 4. Jump to top of ROM, then wrap.
    drive(1, 1, 3'b111, 0, 0, 16'h7FFF);
    drive(1, 0, 3'b000, 0, 0, 0);

    // 5. Unconditional jump-to-self halts; later advances are ignored.
    drive(1, 1, 3'b111, 0, 0, 16'h0010);
    drive(1, 1, 3'b111, 1, 0, 16'h0010);
    repeat (5) drive(1, 1, 3'b111, 0, 1, $urandom);
    do_reset();
    drive(1, 1, 3'b100, 0, 1, 16'h0020);
    drive(1, 1, 3'b010, 1, 0, 16'h0020);
    drive(1, 0, 3'b000, 0, 0, 0);
    // Illegal zr & ng evaluated literally: JLT takes.
    drive(1, 1, 3'b100, 1, 1, 16'h0345);

    // Random traffic, with occasional self-jumps and periodic resets.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 100; i++) begin
        int tgt;
        tgt = ($urandom_range(7) == 0) ? m_pc : int'($urandom_range((1 << W) - 1));
        drive($urandom_range(3) != 0, $urandom_range(1), 3'($urandom_range(7)),
              $urandom_range(1), $urandom_range(1), tgt);
      end
      do_reset();
    end

    // 6. Saturation on the 4-bit counter instance, then reset.
    @(posedge clk);
    #1;
    adv2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      check("cnt4", 32'(cnt2), 32'((i < 15) ? i : 15));
    end
    check("cnt4_pc", 32'(pc2), 32'd20);
    adv2 = 1'b0;
    #2;
    rst2_n = 1'b0;
    #1;
    check("cnt4_reset", 32'(cnt2), 32'd0);
    check("cnt4_reset_pc", 32'(pc2), 32'd0);

    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
